// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline-register bus: ID-stage inputs, EX-stage copies, hazard and bubble-count outputs.
// The register itself uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface id_ex_reg_if #(
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [1:0]        id_wb_ctrl;
  logic [1:0]        id_mem_ctrl;
  logic [3:0]        id_ex_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;

  logic              ex_valid;
  logic [1:0]        ex_wb_ctrl;
  logic [1:0]        ex_mem_ctrl;
  logic [3:0]        ex_ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;

  logic              lu_stall;
  logic [15:0]       bubble_cnt;

  modport slave (
    input  stall, flush, id_valid, id_wb_ctrl, id_mem_ctrl, id_ex_ctrl,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_wb_ctrl, ex_mem_ctrl, ex_ex_ctrl,
           ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           lu_stall, bubble_cnt
  );

  modport master (
    output stall, flush, id_valid, id_wb_ctrl, id_mem_ctrl, id_ex_ctrl,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_wb_ctrl, ex_mem_ctrl, ex_ex_ctrl,
           ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           lu_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and flush/stall/bubble handling.
// Optional feature macro IDEX_BUBBLE_CNT_EN enables the saturating bubble counter.
module id_ex_reg #(
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_reg_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        wb_ctrl;
    logic [1:0]        mem_ctrl;
    logic [3:0]        ex_ctrl;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } stage_t;

  stage_t stage_reg;
  stage_t stage_next;
  logic   lu_hazard;
  logic   load_bubble;

  // Load in EX whose destination feeds either ID source; $zero never creates a dependency.
  assign lu_hazard = rst_n & stage_reg.valid & stage_reg.mem_ctrl[1] & bus.id_valid
                   & (stage_reg.rt != 5'd0)
                   & ((stage_reg.rt == bus.id_rs) | (stage_reg.rt == bus.id_rt));

  assign load_bubble = lu_hazard | ~bus.id_valid;

  always_comb begin
    stage_next = stage_reg;
    if (bus.flush) begin
      stage_next = '0;
    end else if (!bus.stall) begin
      stage_next.rs_data = bus.id_rs_data;
      stage_next.rt_data = bus.id_rt_data;
      stage_next.imm     = bus.id_imm;
      stage_next.rs      = bus.id_rs;
      stage_next.rt      = bus.id_rt;
      stage_next.rd      = bus.id_rd;
      // Bubbles carry data fields but no control, so nothing downstream writes state.
      if (load_bubble) begin
        stage_next.valid    = 1'b0;
        stage_next.wb_ctrl  = 2'b00;
        stage_next.mem_ctrl = 2'b00;
        stage_next.ex_ctrl  = 4'b0000;
      end else begin
        stage_next.valid    = 1'b1;
        stage_next.wb_ctrl  = bus.id_wb_ctrl;
        stage_next.mem_ctrl = bus.id_mem_ctrl;
        stage_next.ex_ctrl  = bus.id_ex_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign bus.lu_stall    = lu_hazard;
  assign bus.ex_valid    = stage_reg.valid;
  assign bus.ex_wb_ctrl  = stage_reg.wb_ctrl;
  assign bus.ex_mem_ctrl = stage_reg.mem_ctrl;
  assign bus.ex_ex_ctrl  = stage_reg.ex_ctrl;
  assign bus.ex_rs_data  = stage_reg.rs_data;
  assign bus.ex_rt_data  = stage_reg.rt_data;
  assign bus.ex_imm      = stage_reg.imm;
  assign bus.ex_rs       = stage_reg.rs;
  assign bus.ex_rt       = stage_reg.rt;
  assign bus.ex_rd       = stage_reg.rd;

`ifdef IDEX_BUBBLE_CNT_EN
  logic        bubble_event;
  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;

  assign bubble_event = bus.flush | (~bus.stall & load_bubble);

  always_comb begin
    cnt_next = cnt_reg;
    if (bubble_event && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 16'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bus.bubble_cnt = cnt_reg;
`else
  assign bus.bubble_cnt = 16'd0;
`endif

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of register-data and immediate fields.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold all ID/EX state this cycle (downstream back-pressure).
REQ-005 flush  input  1  replace ID/EX contents with a bubble (branch/jump redirect).
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_wb_ctrl  input  2  {RegWrite, MemtoReg}.
REQ-008 id_mem_ctrl  input  2  {MemRead, MemWrite}.
REQ-009 id_ex_ctrl  input  4  {RegDst, ALUSrc, ALUOp[1:0]}.
REQ-010 id_rs_data, id_rt_data, id_imm  input  DATA_W each  operand A, operand B, sign-extended immediate.
REQ-011 id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-012 ex_valid, ex_wb_ctrl, ex_mem_ctrl, ex_ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd  output  widths as matching id_* (ex_valid 1)  registered EX-stage copies.
REQ-013 lu_stall  output  1  load-use hazard; upstream PC and IF/ID shall hold when high.
REQ-014 bubble_cnt  output  16  count of bubbles inserted (see Configuration).

Function
REQ-015 lu_stall SHALL be combinational: ex_valid & ex_mem_ctrl[1] & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-016 Per rising edge, priority: flush > stall > bubble-load > normal-load.
REQ-017 flush=1: every ex_* output SHALL become 0, regardless of stall.
REQ-018 flush=0, stall=1: every ex_* output SHALL hold its value.
REQ-019 Bubble-load (flush=0, stall=0, and lu_stall=1 or id_valid=0): ex_valid, ex_wb_ctrl, ex_mem_ctrl, ex_ex_ctrl SHALL become 0; data and specifier fields load from id_* (don't-care downstream).
REQ-020 Normal-load: every ex_* output SHALL take its id_* value, one-cycle latency; ex_valid becomes 1.
REQ-021 A bubble SHALL never assert RegWrite, MemRead or MemWrite downstream.
REQ-022 lu_stall while stall=1 SHALL NOT insert a bubble; state holds and hazard is re-evaluated next cycle.
REQ-023 No arithmetic on data fields; all widths pass through unchanged.

Reset
REQ-024 rst_n low SHALL clear all ex_* outputs and bubble_cnt to 0 immediately, independent of clk.
REQ-025 Reset asserted mid-stall or mid-hazard SHALL discard held state; lu_stall SHALL read 0 during reset.
REQ-026 First edge after rst_n deassertion SHALL behave per REQ-016.

Configuration
REQ-027 Macro IDEX_BUBBLE_CNT_EN defined: bubble_cnt SHALL increment by 1 on each edge performing flush or bubble-load (REQ-017/019, stall=0 or flush=1), saturating at 16'hFFFF; holds otherwise.
REQ-028 Macro IDEX_BUBBLE_CNT_EN undefined: bubble_cnt port SHALL exist and be constant 0; no counter flops.

Verification
REQ-029 Normal: id_valid=1, id_wb_ctrl=2'b10, id_rs_data=32'h0000_1234, stall=flush=0 -> next edge ex_valid=1, ex_wb_ctrl=2'b10, ex_rs_data=32'h0000_1234.
REQ-030 Load-use: EX holds lw (ex_mem_ctrl=2'b10, ex_rt=5'd8, ex_valid=1), ID id_rs=5'd8 -> lu_stall=1; next edge ex_valid=0, all ctrl 0; bubble_cnt +1 if enabled.
REQ-031 $zero: same as REQ-030 with ex_rt=id_rs=5'd0 -> lu_stall=0, normal load.
REQ-032 Stall+flush same cycle with ex_valid=1 -> next edge all ex_* = 0; stall alone for 3 cycles -> ex_* unchanged for 3 edges.
REQ-033 Async reset: drive rst_n=0 between edges with ex_valid=1 -> ex_* and bubble_cnt 0 before next edge; no change on edges while low.
REQ-034 Saturation (IDEX_BUBBLE_CNT_EN): force 65536 consecutive flushes -> bubble_cnt=16'hFFFF and stays there on further flushes.
